cpu_trace_buf: RTL and testbench
================================

# cpu_trace_buf

Instruction trace capture buffer that sits downstream of the single-cycle `cpu`. It samples the core's per-cycle debug outputs (PC, instruction word, ALU result, ALU flags) into a circular buffer. After a stop condition, it drains the captured history over a valid/ready read port to the bench or a debug host. Capture is passive: the block never stalls or alters the core.

## Interface
- `DEPTH`, 16: entries in buffer; power of two, ≥4. `AW = log2(DEPTH)`.
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `arm`  in  1  single-cycle pulse: clear buffer and start capture.
- `pc_in`  in  32  core `pc_out`.
- `inst_in`  in  32  core `inst`.
- `alu_in`  in  32  core `alu_out`.
- `flags_in`  in  3  {overflow, zero, carryout} from core ALU.
- `trig_pc`  in  32  trigger PC (used only with `TRACE_TRIG_EN`).
- `post_cnt`  in  AW  samples after trigger sample (used only with `TRACE_TRIG_EN`).
- `rd_ready`  in  1  consumer accepts current entry.
- `rd_valid`  out  1  entry presented on `rd_*`.
- `rd_pc`, `rd_inst`, `rd_alu`  out  32 each  entry fields; 0 whenever `rd_valid`=0.
- `rd_flags`  out  3  entry flags; 0 whenever `rd_valid`=0.
- `state`  out  2  IDLE=0, CAPTURE=1, POST=2, DUMP=3.
- `count`  out  AW+1  valid entries held, 0..DEPTH.
- `overrun`  out  1  at least one entry overwritten since last arm.

## Operation
- Entry = {pc, inst, alu, flags}, 99 bits. Write pointer `wr_ptr` (AW bits) wraps DEPTH-1→0.
- IDLE: `arm` → CAPTURE; clear `wr_ptr`, `count` and `overrun`.
- CAPTURE: store one entry per cycle at `wr_ptr`, then increment `wr_ptr`.
  - `count` increments and saturates at DEPTH.
  - A write while `count`=DEPTH overwrites the oldest entry and sets `overrun`.
- CAPTURE exit depends on `TRACE_TRIG_EN` (see Configuration).
- POST: store one entry per cycle, decrement the latched remaining count. The write that brings it to 0 → DUMP.
- DUMP: read pointer starts at the oldest entry, `wr_ptr - count` mod DEPTH.
  - `rd_valid` = (`count`≠0).
  - Transfer on `rd_valid & rd_ready`: increment read pointer, decrement `count`.
  - When `count` reaches 0 → IDLE.
- `arm` in CAPTURE/POST restarts capture exactly as from IDLE. `arm` in DUMP is ignored.
- `rst` low at any time: all outputs 0, state IDLE, pointers 0, storage contents irrelevant (outputs gated by `rd_valid`).

## Timing
- `arm` is sampled at edge N; state=CAPTURE after N. First sample is taken at edge N+1.
- Inputs are sampled on the same edge they are stored; no input pipeline.
- Trigger compare is combinational on `pc_in` during CAPTURE. The matching sample is stored on the trigger edge. `post_cnt` is latched on that edge.
- `rd_valid` rises in the cycle following the final capture edge.
- Read data comes from the array combinationally at the read pointer. It holds stable while `rd_ready`=0.
- Throughput is one entry per cycle with `rd_ready` held high.

## Configuration
- `TRACE_TRIG_EN` defined:
  - CAPTURE runs circularly until `pc_in`==`trig_pc`.
  - `post_cnt`=0 → DUMP directly on the trigger edge; otherwise → POST.
  - `overrun` is meaningful.
- Undefined:
  - CAPTURE stops after exactly DEPTH samples → DUMP.
  - POST is unreachable, `overrun` is always 0, and `trig_pc`/`post_cnt` are ignored.

## Test plan
- Reset: `rst`=0 mid-CAPTURE → immediately `state`=0, `count`=0, `rd_valid`=0, `overrun`=0, all `rd_*`=0.
- No trigger (macro off, DEPTH=16): arm, PC steps 0x0,0x4,…
  - After 16 sample edges: `state`=3, `count`=16.
  - Readout with `rd_ready`=1 yields `rd_pc` 0x00..0x3C in order, then `state`=0.
- Trigger wrap (macro on): `trig_pc`=0x40, `post_cnt`=3, PC steps by 4 from 0.
  - 20 samples are taken; `overrun`=1, `count`=16.
  - Readout gives 0x10..0x4C.
- Early trigger (macro on): `trig_pc`=0x8, `post_cnt`=0 → `count`=3, `overrun`=0, entries 0x0,0x4,0x8.
- Backpressure: during DUMP toggle `rd_ready` 1,0,1,0 → `rd_pc` holds while low; every entry is delivered exactly once; 16 entries take 32 cycles.
- Reset/re-arm: assert `rst` after 5 reads → IDLE. Re-arm and rerun the no-trigger case → identical results; `arm` pulses during DUMP have no effect.

Source files
------------

// File: rtl/cpu_trace_buf.sv
// Passive instruction-trace capture buffer for the single-cycle cpu, drained over a valid/ready port.
// Optional trigger/post-trigger capture is built when TRACE_TRIG_EN is defined.
module cpu_trace_buf #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   inst_in,
  input  logic [31:0]   alu_in,
  input  logic [2:0]    flags_in,
  input  logic [31:0]   trig_pc,
  input  logic [AW-1:0] post_cnt,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_inst,
  output logic [31:0]   rd_alu,
  output logic [2:0]    rd_flags,
  output logic [1:0]    state,
  output logic [AW:0]   count,
  output logic          overrun
);

  // state   | meaning
  // IDLE    | waiting for arm
  // CAPTURE | storing one sample per cycle until stop condition
  // POST    | storing the remaining post-trigger samples
  // DUMP    | presenting held entries oldest-first on the read port
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CAPTURE = 2'd1, S_POST = 2'd2, S_DUMP = 2'd3} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          we;
  logic [AW-1:0] rd_ptr;
  logic [98:0]   rd_entry;
  logic [98:0]   mem_q [DEPTH];

`ifdef TRACE_TRIG_EN
  logic [AW-1:0] post_q, post_d;
`else
  logic          unused_trig;
  assign unused_trig = ^{trig_pc, post_cnt};
`endif

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    we        = 1'b0;
`ifdef TRACE_TRIG_EN
    post_d    = post_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d   = S_CAPTURE;
          wr_ptr_d  = '0;
          count_d   = '0;
          overrun_d = 1'b0;
        end
      end
      S_CAPTURE, S_POST: begin
        if (arm) begin
          state_d   = S_CAPTURE;
          wr_ptr_d  = '0;
          count_d   = '0;
          overrun_d = 1'b0;
        end else begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (count_q != FULL) count_d = count_q + 1'b1;
`ifdef TRACE_TRIG_EN
          // A full buffer drops its oldest entry; the read side finds it via wr_ptr - count.
          if (count_q == FULL) overrun_d = 1'b1;
          if (state_q == S_CAPTURE) begin
            if (pc_in == trig_pc) begin
              if (post_cnt == '0) begin
                state_d = S_DUMP;
              end else begin
                state_d = S_POST;
                post_d  = post_cnt;
              end
            end
          end else begin
            post_d = post_q - 1'b1;
            if (post_q == AW'(1)) state_d = S_DUMP;
          end
`else
          if (state_q == S_POST || count_q == FULL - 1'b1) state_d = S_DUMP;
`endif
        end
      end
      S_DUMP: begin
        if (count_q == '0) begin
          state_d = S_IDLE;
        end else if (rd_ready) begin
          count_d = count_q - 1'b1;
          if (count_q == (AW+1)'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
`ifdef TRACE_TRIG_EN
      post_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
`ifdef TRACE_TRIG_EN
      post_q    <= post_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q] <= {pc_in, inst_in, alu_in, flags_in};
  end

  // Oldest entry sits count places behind the write pointer; draining walks it forward.
  assign rd_ptr   = wr_ptr_q - count_q[AW-1:0];
  assign rd_entry = mem_q[rd_ptr];

  assign rd_valid = (state_q == S_DUMP) && (count_q != '0);
  assign rd_pc    = rd_valid ? rd_entry[98:67] : 32'd0;
  assign rd_inst  = rd_valid ? rd_entry[66:35] : 32'd0;
  assign rd_alu   = rd_valid ? rd_entry[34:3]  : 32'd0;
  assign rd_flags = rd_valid ? rd_entry[2:0]   : 3'd0;
  assign state    = state_q;
  assign count    = count_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_cpu_trace_buf.sv
// Directed scoreboard bench for cpu_trace_buf; trigger scenarios run when TRACE_TRIG_EN is defined.
module tb_cpu_trace_buf;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arm = 1'b0;
  logic [31:0]   pc_in = '0, inst_in = '0, alu_in = '0, trig_pc = '0;
  logic [2:0]    flags_in = '0;
  logic [AW-1:0] post_cnt = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [31:0]   rd_pc, rd_inst, rd_alu;
  logic [2:0]    rd_flags;
  logic [1:0]    state;
  logic [AW:0]   count;
  logic          overrun;

  cpu_trace_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .arm(arm), .pc_in(pc_in), .inst_in(inst_in), .alu_in(alu_in),
    .flags_in(flags_in), .trig_pc(trig_pc), .post_cnt(post_cnt), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_alu(rd_alu), .rd_flags(rd_flags),
    .state(state), .count(count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [$];
  logic        m_over = 1'b0;

  function automatic logic [31:0] f_inst(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction
  function automatic logic [31:0] f_alu(input logic [31:0] pc);
    return pc * 32'd3 + 32'd1;
  endfunction
  function automatic logic [2:0] f_flags(input logic [31:0] pc);
    return pc[4:2];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    model.delete();
    m_over = 1'b0;
  endtask

  task automatic sample(input logic [31:0] pc);
    pc_in    = pc;
    inst_in  = f_inst(pc);
    alu_in   = f_alu(pc);
    flags_in = f_flags(pc);
    if (model.size() == DEPTH) begin
      void'(model.pop_front());
      m_over = 1'b1;
    end
    model.push_back(pc);
    step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 64'(state), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_valid"}, 64'(rd_valid), 64'd0);
    check({tag, "_overrun"}, 64'(overrun), 64'd0);
    check({tag, "_rd_zero"}, {rd_pc, rd_inst ^ rd_alu, 29'd0, rd_flags}, 64'd0);
  endtask

  // toggle: rd_ready alternates 0,1,...; poke_arm: pulse arm every third cycle while dumping
  task automatic drain(input string tag, input bit toggle, input bit poke_arm,
                       output int cyc, output int xfers);
    logic [31:0] prev_pc;
    bit          prev_low;
    cyc = 0; xfers = 0; prev_low = 1'b0; prev_pc = '0;
    while (state == 2'd3 && cyc < 200) begin
      rd_ready = toggle ? cyc[0] : 1'b1;
      arm      = poke_arm && (cyc % 3 == 1);
      if (model.size() == 0) begin
        check({tag, "_extra_valid"}, 64'(rd_valid), 64'd0);
        break;
      end
      check({tag, "_valid"}, 64'(rd_valid), 64'd1);
      check({tag, "_pc"}, 64'(rd_pc), 64'(model[0]));
      check({tag, "_inst"}, 64'(rd_inst), 64'(f_inst(model[0])));
      check({tag, "_alu"}, 64'(rd_alu), 64'(f_alu(model[0])));
      check({tag, "_flags"}, 64'(rd_flags), 64'(f_flags(model[0])));
      if (prev_low) check({tag, "_hold"}, 64'(rd_pc), 64'(prev_pc));
      prev_pc  = rd_pc;
      prev_low = !rd_ready;
      step();
      if (rd_ready) begin
        void'(model.pop_front());
        xfers++;
      end
      cyc++;
    end
    rd_ready = 1'b0;
    arm      = 1'b0;
    check({tag, "_end_state"}, 64'(state), 64'd0);
    check({tag, "_leftover"}, 64'(model.size()), 64'd0);
    check({tag, "_end_valid"}, 64'(rd_valid), 64'd0);
    check({tag, "_end_pc"}, 64'(rd_pc), 64'd0);
  endtask

  int cyc, xfers, n;

  initial begin
    step();
    step();
    check_reset("por");
    rst = 1'b1;
    step();

    // Reset mid-capture
    do_arm();
    check("arm_state", 64'(state), 64'd1);
    for (int i = 0; i < 7; i++) sample(32'(i * 4));
    check("midcap_state", 64'(state), 64'd1);
    check("midcap_count", 64'(count), 64'd7);
    rst = 1'b0;
    #2;
    check_reset("rst_cap");
    rst = 1'b1;
    step();

`ifndef TRACE_TRIG_EN
    // Plain capture: exactly DEPTH samples, then oldest-first readout
    do_arm();
    for (int i = 0; i < 16; i++) sample(32'(i * 4));
    check("nt_state", 64'(state), 64'd3);
    check("nt_count", 64'(count), 64'd16);
    check("nt_overrun", 64'(overrun), 64'd0);
    check("nt_first_pc", 64'(rd_pc), 64'h0);
    drain("nt", 1'b0, 1'b0, cyc, xfers);
    check("nt_xfers", 64'(xfers), 64'd16);

    // Backpressure: one entry per two cycles
    do_arm();
    for (int i = 0; i < 16; i++) sample(32'h100 + 32'(i * 4));
    drain("bp", 1'b1, 1'b0, cyc, xfers);
    check("bp_xfers", 64'(xfers), 64'd16);
    check("bp_cycles", 64'(cyc), 64'd32);

    // Reset after five reads, then rerun with arm pulses during dump
    do_arm();
    for (int i = 0; i < 16; i++) sample(32'(i * 4));
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("r5_count", 64'(count), 64'd11);
    check("r5_pc", 64'(rd_pc), 64'h14);
    rd_ready = 1'b0;
    rst = 1'b0;
    #2;
    check_reset("rst_dump");
    rst = 1'b1;
    step();
    do_arm();
    for (int i = 0; i < 16; i++) sample(32'(i * 4));
    check("re_state", 64'(state), 64'd3);
    check("re_count", 64'(count), 64'd16);
    drain("re", 1'b0, 1'b1, cyc, xfers);
    check("re_xfers", 64'(xfers), 64'd16);
`else
    // Trigger after wrap: 17 samples to the trigger plus 3 post samples
    trig_pc  = 32'h40;
    post_cnt = AW'(3);
    do_arm();
    n = 0;
    while (state != 2'd3 && n < 40) begin
      sample(32'(n * 4));
      n++;
    end
    check("tw_samples", 64'(n), 64'd20);
    check("tw_state", 64'(state), 64'd3);
    check("tw_overrun", 64'(overrun), 64'd1);
    check("tw_model_over", 64'(m_over), 64'd1);
    check("tw_count", 64'(count), 64'd16);
    check("tw_first_pc", 64'(rd_pc), 64'h10);
    drain("tw", 1'b0, 1'b0, cyc, xfers);
    check("tw_xfers", 64'(xfers), 64'd16);

    // Early trigger with no post samples
    trig_pc  = 32'h8;
    post_cnt = '0;
    do_arm();
    n = 0;
    while (state != 2'd3 && n < 40) begin
      sample(32'(n * 4));
      n++;
    end
    check("et_samples", 64'(n), 64'd3);
    check("et_count", 64'(count), 64'd3);
    check("et_overrun", 64'(overrun), 64'd0);
    drain("et", 1'b1, 1'b1, cyc, xfers);
    check("et_xfers", 64'(xfers), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
